// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the two-master sram-like arbiter: owner tags,
// transfer sizes and arbiter FSM states.
package sram_like_arbiter_pkg;

   localparam logic OWNER_M0 = 1'b0;
   localparam logic OWNER_M1 = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order owner tag FIFO: one bit per accepted request, popped as each
// response returns so the response can be steered to its issuing master.
module sram_like_arbiter_owner_fifo
   import sram_like_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       din,
   output logic                       head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? OWNER_M0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Tag storage carries no reset; only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two sram-like masters (m0 fetch, m1 data) onto one sram-like slave port,
// with an owner FIFO routing in-order responses back to the issuing master.
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter bit          M1_PRIORITY     = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [1:0]  m0_size,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_addr_ok,
   output logic        m0_data_ok,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [1:0]  m1_size,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_addr_ok,
   output logic        m1_data_ok,
   output logic [31:0] m1_rdata,
   output logic        s_req,
   output logic        s_wr,
   output logic [1:0]  s_size,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic        s_addr_ok,
   input  logic        s_data_ok,
   input  logic [31:0] s_rdata,
   output logic        busy
);

   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   arb_state_e    state_q, state_d;
   logic          grant, grant_q;
   logic          req_sel;
   logic          accept;
   logic          pop;
   logic          fifo_head, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ARB_IDLE;
         grant_q <= OWNER_M0;
      end else begin
         state_q <= state_d;
         grant_q <= grant;
      end
   end

   // Grant is free-running in IDLE and frozen in LOCK so a stalled request
   // keeps its fields on the slave port until it is accepted.
   always_comb begin
      grant   = grant_q;
      state_d = state_q;
      if (state_q == ARB_IDLE) begin
         if (m0_req && m1_req) grant = M1_PRIORITY ? OWNER_M1 : OWNER_M0;
         else if (m1_req)      grant = OWNER_M1;
         else if (m0_req)      grant = OWNER_M0;
      end
      req_sel = (grant == OWNER_M1) ? m1_req : m0_req;
      s_req   = resetn && req_sel && !fifo_full;
      case (state_q)
         ARB_IDLE: if (s_req && !s_addr_ok) state_d = ARB_LOCK;
         ARB_LOCK: if (s_addr_ok || !s_req) state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   assign accept = s_req && s_addr_ok;
   assign pop    = resetn && s_data_ok && !fifo_empty;

   assign s_wr    = resetn && ((grant == OWNER_M1) ? m1_wr : m0_wr);
   assign s_size  = !resetn ? 2'd0  : (grant == OWNER_M1) ? m1_size  : m0_size;
   assign s_wstrb = !resetn ? 4'd0  : (grant == OWNER_M1) ? m1_wstrb : m0_wstrb;
   assign s_addr  = !resetn ? 32'd0 : (grant == OWNER_M1) ? m1_addr  : m0_addr;
   assign s_wdata = !resetn ? 32'd0 : (grant == OWNER_M1) ? m1_wdata : m0_wdata;

   assign m0_addr_ok = accept && (grant == OWNER_M0);
   assign m1_addr_ok = accept && (grant == OWNER_M1);
   assign m0_data_ok = pop && (fifo_head == OWNER_M0);
   assign m1_data_ok = pop && (fifo_head == OWNER_M1);
   assign m0_rdata   = resetn ? s_rdata : 32'd0;
   assign m1_rdata   = resetn ? s_rdata : 32'd0;

   assign busy = resetn && ((fifo_count != '0) || (state_q == ARB_LOCK));

   sram_like_arbiter_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (accept),
      .pop    (pop),
      .din    (grant),
      .head   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (resetn) begin
         assert (!(s_data_ok && fifo_empty))
            else $error("s_data_ok with no outstanding request");
         assert (!s_req || (s_size inside {SIZE_BYTE, SIZE_HALF, SIZE_WORD}))
            else $error("illegal s_size on slave request");
      end
   end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a per-cycle vector table plus
// hand-written sequences for the full-FIFO and mid-operation reset cases.
module tb_sram_like_arbiter;
   import sram_like_arbiter_pkg::*;

   localparam logic [31:0] A0 = 32'hBFC0_0000;
   localparam logic [31:0] A1 = 32'h8000_1000;
   localparam logic [31:0] W0 = 32'h0BAD_F00D;
   localparam logic [31:0] W1 = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [1:0]  m0_size, m1_size;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_req, s_wr, s_addr_ok, s_data_ok, busy;
   logic [1:0]  s_size;
   logic [3:0]  s_wstrb;
   logic [31:0] s_addr, s_wdata, s_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sram_like_arbiter #(
      .MAX_OUTSTANDING (4),
      .M1_PRIORITY     (1'b1)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .m0_req     (m0_req),
      .m0_wr      (m0_wr),
      .m0_size    (m0_size),
      .m0_wstrb   (m0_wstrb),
      .m0_addr    (m0_addr),
      .m0_wdata   (m0_wdata),
      .m0_addr_ok (m0_addr_ok),
      .m0_data_ok (m0_data_ok),
      .m0_rdata   (m0_rdata),
      .m1_req     (m1_req),
      .m1_wr      (m1_wr),
      .m1_size    (m1_size),
      .m1_wstrb   (m1_wstrb),
      .m1_addr    (m1_addr),
      .m1_wdata   (m1_wdata),
      .m1_addr_ok (m1_addr_ok),
      .m1_data_ok (m1_data_ok),
      .m1_rdata   (m1_rdata),
      .s_req      (s_req),
      .s_wr       (s_wr),
      .s_size     (s_size),
      .s_wstrb    (s_wstrb),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_addr_ok  (s_addr_ok),
      .s_data_ok  (s_data_ok),
      .s_rdata    (s_rdata),
      .busy       (busy)
   );

   typedef struct {
      logic        m0_req;
      logic        m1_req;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic        e_sreq;
      logic [31:0] e_addr;
      logic        e_m0aok;
      logic        e_m1aok;
      logic        e_m0dok;
      logic        e_m1dok;
      logic        e_busy;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic add(input logic a, input logic b, input logic c, input logic d,
                      input logic [31:0] rd, input logic es, input logic [31:0] ea,
                      input logic e0a, input logic e1a, input logic e0d, input logic e1d,
                      input logic eb);
      vec_t v;
      v.m0_req = a;   v.m1_req = b;   v.aok = c;      v.dok = d;
      v.rdata = rd;   v.e_sreq = es;  v.e_addr = ea;
      v.e_m0aok = e0a; v.e_m1aok = e1a; v.e_m0dok = e0d; v.e_m1dok = e1d;
      v.e_busy = eb;
      vq.push_back(v);
   endtask

   task automatic drive(input logic a, input logic b, input logic c, input logic d,
                        input logic [31:0] rd);
      m0_req = a; m1_req = b; s_addr_ok = c; s_data_ok = d; s_rdata = rd;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " s_req"},      s_req, 0);
      chk({tag, " s_wr"},       s_wr, 0);
      chk({tag, " s_size"},     s_size, 0);
      chk({tag, " s_wstrb"},    s_wstrb, 0);
      chk({tag, " s_addr"},     s_addr, 0);
      chk({tag, " s_wdata"},    s_wdata, 0);
      chk({tag, " m0_addr_ok"}, m0_addr_ok, 0);
      chk({tag, " m1_addr_ok"}, m1_addr_ok, 0);
      chk({tag, " m0_data_ok"}, m0_data_ok, 0);
      chk({tag, " m1_data_ok"}, m1_data_ok, 0);
      chk({tag, " m0_rdata"},   m0_rdata, 0);
      chk({tag, " m1_rdata"},   m1_rdata, 0);
      chk({tag, " busy"},       busy, 0);
   endtask

   initial begin
      resetn = 1'b0;
      m0_wr = 1'b0; m0_size = SIZE_WORD; m0_wstrb = 4'hF; m0_addr = A0; m0_wdata = W0;
      m1_wr = 1'b1; m1_size = SIZE_HALF; m1_wstrb = 4'h3; m1_addr = A1; m1_wdata = W1;
      drive(1, 1, 1, 1, 32'h1234_5678);

      // Single m0 read, accepted after two stall cycles, answered three later.
      add(1,0,0,0, 32'h0,          1, A0, 0,0,0,0, 0);
      add(1,0,0,0, 32'h0,          1, A0, 0,0,0,0, 1);
      add(1,0,1,0, 32'h0,          1, A0, 1,0,0,0, 1);
      add(0,0,0,0, 32'h0,          0, A0, 0,0,0,0, 1);
      add(0,0,0,0, 32'h0,          0, A0, 0,0,0,0, 1);
      add(0,0,0,1, 32'h3C1D_BFC0,  0, A0, 0,0,1,0, 1);
      add(0,0,0,0, 32'h0,          0, A0, 0,0,0,0, 0);
      // Simultaneous requests: m1 first, then m0; push+pop at count 2.
      add(1,1,1,0, 32'h0,          1, A1, 0,1,0,0, 0);
      add(1,0,1,0, 32'h0,          1, A0, 1,0,0,0, 1);
      add(1,0,1,1, 32'h1111_1111,  1, A0, 1,0,0,1, 1);
      add(0,1,1,1, 32'h2222_2222,  1, A1, 0,1,1,0, 1);
      add(0,0,0,1, 32'h3333_3333,  0, A0, 0,0,1,0, 1);
      add(0,0,0,1, 32'h4444_4444,  0, A0, 0,0,0,1, 1);
      add(0,0,0,0, 32'h0,          0, A0, 0,0,0,0, 0);
      // m0 stalled in LOCK for three cycles while m1 waits.
      add(1,0,0,0, 32'h0,          1, A0, 0,0,0,0, 0);
      add(1,1,0,0, 32'h0,          1, A0, 0,0,0,0, 1);
      add(1,1,0,0, 32'h0,          1, A0, 0,0,0,0, 1);
      add(1,1,1,0, 32'h0,          1, A0, 1,0,0,0, 1);
      add(0,1,1,0, 32'h0,          1, A1, 0,1,0,0, 1);
      add(0,0,0,1, 32'h5555_5555,  0, A0, 0,0,1,0, 1);
      add(0,0,0,1, 32'h6666_6666,  0, A0, 0,0,0,1, 1);
      add(0,0,0,0, 32'h0,          0, A0, 0,0,0,0, 0);

      #1;
      check_all_zero("in_reset");
      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0);
      resetn = 1'b1;

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].m0_req, vq[i].m1_req, vq[i].aok, vq[i].dok, vq[i].rdata);
         #1;
         chk($sformatf("row%0d s_req", i),      s_req,      vq[i].e_sreq);
         chk($sformatf("row%0d m0_addr_ok", i), m0_addr_ok, vq[i].e_m0aok);
         chk($sformatf("row%0d m1_addr_ok", i), m1_addr_ok, vq[i].e_m1aok);
         chk($sformatf("row%0d m0_data_ok", i), m0_data_ok, vq[i].e_m0dok);
         chk($sformatf("row%0d m1_data_ok", i), m1_data_ok, vq[i].e_m1dok);
         chk($sformatf("row%0d m0_rdata", i),   m0_rdata,   vq[i].rdata);
         chk($sformatf("row%0d m1_rdata", i),   m1_rdata,   vq[i].rdata);
         chk($sformatf("row%0d busy", i),       busy,       vq[i].e_busy);
         if (vq[i].e_sreq) begin
            chk($sformatf("row%0d s_addr", i),  s_addr, vq[i].e_addr);
            chk($sformatf("row%0d s_wdata", i), s_wdata, (vq[i].e_addr == A1) ? W1 : W0);
            chk($sformatf("row%0d s_wr", i),    s_wr, (vq[i].e_addr == A1) ? 1'b1 : 1'b0);
            chk($sformatf("row%0d s_size", i),  s_size,
                (vq[i].e_addr == A1) ? SIZE_HALF : SIZE_WORD);
            chk($sformatf("row%0d s_wstrb", i), s_wstrb, (vq[i].e_addr == A1) ? 4'h3 : 4'hF);
         end
      end

      // Slave accepts everything and never answers: only four get in.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive(1, 0, 1, 0, 32'h0);
         #1;
         chk($sformatf("full%0d s_req", k),      s_req,      (k < 4) ? 1'b1 : 1'b0);
         chk($sformatf("full%0d m0_addr_ok", k), m0_addr_ok, (k < 4) ? 1'b1 : 1'b0);
         if (k > 0) chk($sformatf("full%0d busy", k), busy, 1'b1);
      end
      @(negedge clk);
      drive(1, 0, 1, 1, 32'h7777_7777);
      #1;
      chk("full_pop s_req",      s_req, 0);
      chk("full_pop m0_addr_ok", m0_addr_ok, 0);
      chk("full_pop m0_data_ok", m0_data_ok, 1);
      @(negedge clk);
      drive(1, 0, 1, 0, 32'h0);
      #1;
      chk("reopen s_req",      s_req, 1);
      chk("reopen m0_addr_ok", m0_addr_ok, 1);
      @(negedge clk);
      drive(0, 0, 0, 1, 32'h0);
      #1;
      chk("drain m0_data_ok", m0_data_ok, 1);

      // Reset with three requests outstanding and every input active.
      @(negedge clk);
      drive(1, 1, 1, 1, 32'h8888_8888);
      resetn = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk);
      drive(0, 1, 1, 0, 32'h0);
      resetn = 1'b1;
      #1;
      chk("post_reset busy",       busy, 0);
      chk("post_reset s_req",      s_req, 1);
      chk("post_reset s_addr",     s_addr, A1);
      chk("post_reset m1_addr_ok", m1_addr_ok, 1);
      @(negedge clk);
      drive(0, 0, 0, 1, 32'h9999_9999);
      #1;
      chk("post_reset m1_data_ok", m1_data_ok, 1);
      chk("post_reset m0_data_ok", m0_data_ok, 0);
      chk("post_reset m1_rdata",   m1_rdata, 32'h9999_9999);
      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0);
      #1;
      chk("post_reset idle busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Arbitrates two sram-like masters, m0 (instruction fetch) and m1 (data access), onto one sram-like slave port. The slave port feeds the AXI bridge. Acceptances are recorded in an in-order owner FIFO so that each s_data_ok and its s_rdata return only to the master that issued the request. The block sits between the CPU core and the AXI interface.

Parameters:
MAX_OUTSTANDING, 4, depth of the owner FIFO (power of 2, 2..16); caps accepted-but-unanswered requests.
M1_PRIORITY, 1, when 1 m1 wins simultaneous requests; when 0 m0 wins.

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
m0_req, m1_req in / s_req out  1  request valid
m0_wr, m1_wr in / s_wr out  1  1=write
m0_size, m1_size in / s_size out  2  0=byte 1=half 2=word
m0_wstrb, m1_wstrb in / s_wstrb out  4  byte enables
m0_addr, m1_addr in / s_addr out  32  address
m0_wdata, m1_wdata in / s_wdata out  32  write data
m0_addr_ok, m1_addr_ok out / s_addr_ok in  1  request accepted
m0_data_ok, m1_data_ok out / s_data_ok in  1  response (read data or write done)
m0_rdata, m1_rdata out / s_rdata in  32  read data; s_rdata is fanned out unmodified to both
busy  out  1  owner FIFO non-empty or grant locked

Behaviour:
- Reset: clk single clock; resetn asynchronous active-low. State = IDLE, FIFO count = 0, grant = m0. All outputs are 0 while resetn is low.
- States:
  - IDLE: grant is chosen combinationally from this cycle's requests, using M1_PRIORITY on ties.
  - LOCK: grant is held while s_req=1 and s_addr_ok=0.
- IDLE -> LOCK when s_req=1 and s_addr_ok=0. LOCK -> IDLE on s_addr_ok=1.
- A master's fields cannot switch onto the slave port mid-handshake. A higher-priority request arriving in LOCK waits.
- Request muxing:
  - s_req = granted master's req AND (count < MAX_OUTSTANDING).
  - s_wr, s_size, s_wstrb, s_addr and s_wdata come from the granted master.
- addr_ok routing: mX_addr_ok = s_addr_ok AND s_req AND (grant==X). The non-granted master always sees addr_ok=0.
- Zero added latency: s_addr_ok returns to the master combinationally in the same cycle.
- Push: on s_req & s_addr_ok, push the owner bit (0=m0, 1=m1).
- Pop: on s_data_ok, pop the head. mX_data_ok = s_data_ok AND (head==X).
- The slave returns responses strictly in acceptance order; the arbiter relies on this.
- Simultaneous push and pop: count is unchanged, the pointers both advance, and the head owner is read before the pop.
- Full (count==MAX_OUTSTANDING): s_req forced to 0 and no addr_ok is given. A pop in that cycle reopens acceptance the next cycle (no same-cycle bypass).
- Empty with s_data_ok=1: the response is dropped, both data_ok stay 0, and the sim-only assertion fires.
- Pointers are log2(MAX_OUTSTANDING) bits and wrap modulo depth. count is log2+1 bits.
- Reset mid-operation: FIFO and lock are cleared immediately. The slave is reset by the same resetn, so no stale responses exist.
- busy = (count != 0) OR (state == LOCK).

Decomposition:
- Shared package holds:
  - owner encoding constants OWNER_M0 = 1'b0 and OWNER_M1 = 1'b1;
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - arbiter state encoding ARB_IDLE and ARB_LOCK.
- One sub-module, owner_fifo: a synchronous 1-bit-wide FIFO.
  - Ports: push, pop, din, head, full, empty, count.
  - Parameter: DEPTH.

Test Plan:
1. Single m0 read of addr 0xBFC00000, slave addr_ok after 2 cycles, data_ok 3 cycles later with rdata 0x3C1DBFC0 -> m0_addr_ok pulses once; m0_data_ok=1 with m0_rdata=0x3C1DBFC0; m1_data_ok stays 0.
2. m0 and m1 request in the same cycle, M1_PRIORITY=1 -> m1 granted first (s_addr=m1_addr), then m0. Responses D1 then D0 return to m1 then m0 respectively.
3. m0 pending in LOCK (s_addr_ok held low 3 cycles), m1 raises req during that window -> s_addr stays m0_addr until accepted; m1 accepted on a following cycle.
4. Slave always accepts and never responds; m0 issues 6 requests with MAX_OUTSTANDING=4 -> exactly 4 accepted, then s_req=0 and busy=1. The first s_data_ok lets the 5th be accepted the following cycle.
5. Push and pop in the same cycle at count=2 (m1 accepted while m0's response returns) -> count stays 2; m0_data_ok=1; the next response goes to the next queued owner.
6. resetn pulled low with 3 requests outstanding -> all outputs 0 immediately, busy=0. After release the first new request is routed correctly with count starting from 0.
